// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding load/store responder with fixed access latency
module data_mem_responder #(
  parameter int WIDTH   = 32,
  parameter int AWIDTH  = 10,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [2:0]        req_op,
  input  logic [WIDTH-1:0]  req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              rsp_err
);

  localparam int WORDS = 2 ** (AWIDTH - 2);
  localparam logic [1:0] LAST = 2'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;

  logic [1:0]        cnt;
  logic              wr_q;
  logic [2:0]        op_q;
  logic [AWIDTH-1:0] addr_q;
  logic [WIDTH-1:0]  wdata_q;
  logic [WIDTH-1:0]  mem [WORDS];

  logic              accept, done, err, do_write;
  logic [AWIDTH-3:0] widx;
  logic [1:0]        lane;
  logic [WIDTH-1:0]  word, load_val, store_data;
  logic [3:0]        be;
  logic [7:0]        sel_b;
  logic [15:0]       sel_h;
  logic              req_ready_nx, rsp_valid_nx, rsp_err_nx;
  logic [WIDTH-1:0]  rsp_rdata_nx;
  logic              unused_addr_hi;

  // Upper address bits alias onto the implemented memory.
  assign unused_addr_hi = ^req_addr[WIDTH-1:AWIDTH];

  assign accept   = (state == IDLE) && req_valid && req_ready;
  assign done     = (state == WAIT) && (cnt == LAST);
  assign widx     = addr_q[AWIDTH-1:2];
  assign lane     = addr_q[1:0];
  assign word     = mem[widx];
  assign sel_b    = word[{lane, 3'b000} +: 8];
  assign sel_h    = addr_q[1] ? word[31:16] : word[15:0];
  assign do_write = done && wr_q && !err;

  always_comb begin
    case (op_q)
      3'b000:  err = 1'b0;
      3'b001:  err = addr_q[0];
      3'b010:  err = (addr_q[1:0] != 2'b00);
      3'b100:  err = wr_q;
      3'b101:  err = wr_q || addr_q[0];
      default: err = 1'b1;
    endcase
  end

  always_comb begin
    case (op_q)
      3'b000:  load_val = {{24{sel_b[7]}}, sel_b};
      3'b001:  load_val = {{16{sel_h[15]}}, sel_h};
      3'b100:  load_val = {24'd0, sel_b};
      3'b101:  load_val = {16'd0, sel_h};
      default: load_val = word;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    case (op_q[1:0])
      2'b00: begin
        be         = 4'b0001 << lane;
        store_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be         = addr_q[1] ? 4'b1100 : 4'b0011;
        store_data = {2{wdata_q[15:0]}};
      end
      default: begin
        be         = 4'b1111;
        store_data = wdata_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= store_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      wr_q      <= 1'b0;
      op_q      <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      req_ready <= req_ready_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_rdata <= rsp_rdata_nx;
      rsp_err   <= rsp_err_nx;
      if (accept) begin
        cnt     <= 2'd0;
        wr_q    <= req_wr;
        op_q    <= req_op;
        addr_q  <= req_addr[AWIDTH-1:0];
        wdata_q <= req_wdata;
      end else if (state == WAIT) begin
        cnt <= cnt + 2'd1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = WAIT;
      WAIT:    if (done) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // req_ready follows the next state, so the RESP->IDLE edge itself never accepts.
  always_comb begin
    req_ready_nx = (state_nx == IDLE);
    rsp_valid_nx = rsp_valid;
    rsp_rdata_nx = rsp_rdata;
    rsp_err_nx   = rsp_err;
    if (done) begin
      rsp_valid_nx = 1'b1;
      rsp_err_nx   = err;
      rsp_rdata_nx = (err || wr_q) ? '0 : load_val;
    end else if ((state == RESP) && rsp_ready) begin
      rsp_valid_nx = 1'b0;
      rsp_rdata_nx = '0;
      rsp_err_nx   = 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed checks for data_mem_responder at LATENCY 1 and 4
module tb_data_mem_responder;

  logic             clk;
  logic [1:0]       rst;
  logic [1:0]       req_valid, req_ready, req_wr, rsp_valid, rsp_ready, rsp_err;
  logic [1:0][2:0]  req_op;
  logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  data_mem_responder #(.WIDTH(32), .AWIDTH(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr(req_wr[0]),
    .req_op(req_op[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  data_mem_responder #(.WIDTH(32), .AWIDTH(10), .LATENCY(4)) dut4 (
    .clk(clk), .rst(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr(req_wr[1]),
    .req_op(req_op[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int d, input logic wr, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid[d] = 1'b1;
    req_wr[d]    = wr;
    req_op[d]    = op;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
  endtask

  // Issues one request, waits for its response and lets it handshake (rsp_ready held 1).
  task automatic run(input int d, input string tag, input logic wr, input logic [2:0] op,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    int lat;
    n = 0;
    while (!req_ready[d] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_ready"}, {31'd0, req_ready[d]}, 32'd1);
    drive(d, wr, op, addr, wdata);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!rsp_valid[d] && lat < 20);
    chk({tag, "_lat"}, lat, (d == 0) ? 32'd1 : 32'd4);
    chk({tag, "_rdata"}, rsp_rdata[d], exp_rdata);
    chk({tag, "_err"}, {31'd0, rsp_err[d]}, {31'd0, exp_err});
    @(posedge clk); #1;
  endtask

  logic [31:0] hold;

  initial begin
    rst = 2'b11;
    req_valid = '0; req_wr = '0; req_op = '0; req_addr = '0; req_wdata = '0;
    rsp_ready = 2'b11;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", {31'd0, req_ready[d]}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata[d], 32'd0);
      chk("rst_rsp_err", {31'd0, rsp_err[d]}, 32'd0);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 2'b00;
    chk("ready_held_low", {31'd0, req_ready[0]}, 32'd0);
    @(posedge clk); #1;
    chk("ready_after_rst", {31'd0, req_ready[0]}, 32'd1);

    run(0, "sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    run(0, "lw_10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    run(0, "sw_20", 1'b1, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0);
    run(0, "sb_21", 1'b1, 3'b000, 32'h21, 32'h80, 32'h0, 1'b0);
    run(0, "lw_20a", 1'b0, 3'b010, 32'h20, 32'h0, 32'h00008000, 1'b0);
    run(0, "lb_21", 1'b0, 3'b000, 32'h21, 32'h0, 32'hFFFFFF80, 1'b0);
    run(0, "lbu_21", 1'b0, 3'b100, 32'h21, 32'h0, 32'h00000080, 1'b0);
    run(0, "sh_22", 1'b1, 3'b001, 32'h22, 32'h8001, 32'h0, 1'b0);
    run(0, "lh_22", 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 1'b0);
    run(0, "lhu_22", 1'b0, 3'b101, 32'h22, 32'h0, 32'h00008001, 1'b0);
    run(0, "lw_20b", 1'b0, 3'b010, 32'h20, 32'h0, 32'h80018000, 1'b0);
    run(0, "lh_20", 1'b0, 3'b001, 32'h20, 32'h0, 32'hFFFF8000, 1'b0);

    run(0, "sw_13_mis", 1'b1, 3'b010, 32'h13, 32'h11111111, 32'h0, 1'b1);
    run(0, "lh_11_mis", 1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1);
    run(0, "op011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    run(0, "sbu_bad", 1'b1, 3'b100, 32'h10, 32'h22222222, 32'h0, 1'b1);
    run(0, "lw_10_kept", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    run(0, "sw_404", 1'b1, 3'b010, 32'h404, 32'h12345678, 32'h0, 1'b0);
    run(0, "lw_004", 1'b0, 3'b010, 32'h004, 32'h0, 32'h12345678, 1'b0);

    // Backpressure: a second request waits behind a stalled response.
    rsp_ready[0] = 1'b0;
    drive(0, 1'b0, 3'b010, 32'h10, 32'h0);
    @(posedge clk); #1;
    drive(0, 1'b0, 3'b010, 32'h20, 32'h0);
    @(posedge clk); #1;
    chk("bp_valid0", {31'd0, rsp_valid[0]}, 32'd1);
    chk("bp_rdata0", rsp_rdata[0], 32'hDEADBEEF);
    hold = rsp_rdata[0];
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, rsp_valid[0]}, 32'd1);
      chk("bp_rdata", rsp_rdata[0], hold);
      chk("bp_req_ready", {31'd0, req_ready[0]}, 32'd0);
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_hs_valid", {31'd0, rsp_valid[0]}, 32'd0);
    chk("bp_hs_ready", {31'd0, req_ready[0]}, 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("bp_acc_ready", {31'd0, req_ready[0]}, 32'd0);
    chk("bp_acc_valid", {31'd0, rsp_valid[0]}, 32'd0);
    @(posedge clk); #1;
    chk("bp2_valid", {31'd0, rsp_valid[0]}, 32'd1);
    chk("bp2_rdata", rsp_rdata[0], 32'h80018000);
    @(posedge clk); #1;

    // LATENCY=4 instance, including a reset that kills a pending store.
    run(1, "l4_sw_40", 1'b1, 3'b010, 32'h40, 32'hA5A5A5A5, 32'h0, 1'b0);
    run(1, "l4_lw_40", 1'b0, 3'b010, 32'h40, 32'h0, 32'hA5A5A5A5, 1'b0);
    drive(1, 1'b1, 3'b010, 32'h40, 32'h5A5A5A5A);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst[1] = 1'b1;
    #1;
    chk("l4_rst_req_ready", {31'd0, req_ready[1]}, 32'd0);
    chk("l4_rst_rsp_valid", {31'd0, rsp_valid[1]}, 32'd0);
    chk("l4_rst_rsp_rdata", rsp_rdata[1], 32'd0);
    chk("l4_rst_rsp_err", {31'd0, rsp_err[1]}, 32'd0);
    @(posedge clk); @(posedge clk); @(posedge clk); @(posedge clk); #1;
    chk("l4_rst_no_rsp", {31'd0, rsp_valid[1]}, 32'd0);
    rst[1] = 1'b0;
    @(posedge clk); #1;
    chk("l4_ready_after_rst", {31'd0, req_ready[1]}, 32'd1);
    run(1, "l4_lw_40_kept", 1'b0, 3'b010, 32'h40, 32'h0, 32'hA5A5A5A5, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
